// File: rtl/pipe_pkg.sv
// Shared pipeline types: operand-forward encodings and the in-flight slot record.
// Used by hazard_ctrl and its per-source comparator hazard_cmp.
package pipe_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } slot_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one decode source register against the EX/MEM/WB slots; purely combinational.
// Hazard rule and forward select depend on HAZARD_FORWARDING_EN.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             used,
  input  slot_t            ex_slot,
  input  slot_t            mem_slot,
  input  slot_t            wb_slot,
  output logic             hazard,
  output fwd_t             fwd
);

  logic m_ex, m_mem, m_wb;
  logic unused_bits;

  function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] r, input logic u);
    return u && (r != '0) && s.valid && s.reg_write && (s.rd == r);
  endfunction

  always_comb begin
    m_ex  = slot_hit(ex_slot, rs, used);
    m_mem = slot_hit(mem_slot, rs, used);
    m_wb  = slot_hit(wb_slot, rs, used);
`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EX cannot be bypassed in time.
    hazard = m_ex && ex_slot.mem_read;
    // EX slot will sit in EX/MEM when this instruction executes; youngest wins.
    if (m_ex) begin
      fwd = FWD_EXMEM;
    end else if (m_mem) begin
      fwd = FWD_MEMWB;
    end else begin
      fwd = FWD_RF;
    end
`else
    hazard = m_ex || m_mem || m_wb;
    fwd    = FWD_RF;
`endif
  end

  assign unused_bits = ^{ex_slot.mem_read, mem_slot.mem_read, wb_slot.mem_read, m_wb};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: zero-latency stall/bubble/flush, registered operand forward selects.
// Forwarding and load-use-only stalling are built in when HAZARD_FORWARDING_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_rs1,
  input  logic [$clog2(NREG)-1:0] id_rs2,
  input  logic                    id_rs2_used,
  input  logic [$clog2(NREG)-1:0] id_rd,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic                    br_taken,
  output logic                    stall,
  output logic                    bubble_ex,
  output logic                    flush_ifid,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic [15:0]             perf_stalls
);

  slot_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  fwd_t        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  logic haz_a, haz_b, hazard;
  fwd_t sel_a, sel_b;

  hazard_cmp u_cmp_a (
    .rs       (id_rs1),
    .used     (1'b1),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .hazard   (haz_a),
    .fwd      (sel_a)
  );

  hazard_cmp u_cmp_b (
    .rs       (id_rs2),
    .used     (id_rs2_used),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .hazard   (haz_b),
    .fwd      (sel_b)
  );

  always_comb begin
    stall         = 1'b0;
    bubble_ex     = 1'b0;
    flush_ifid    = 1'b0;
    hazard        = id_valid && (haz_a || haz_b);

    // A taken branch kills the decode instruction, so its hazard is moot.
    if (br_taken) begin
      flush_ifid = 1'b1;
      bubble_ex  = 1'b1;
    end else if (hazard) begin
      stall      = 1'b1;
      bubble_ex  = 1'b1;
    end

    wb_d  = mem_q;
    mem_d = ex_q;
    if (bubble_ex || !id_valid) begin
      ex_d    = '0;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      fwd_a_d        = sel_a;
      fwd_b_d        = sel_b;
    end

    perf_stalls_d = perf_stalls_q;
    if (stall && (perf_stalls_q != 16'hFFFF)) begin
      perf_stalls_d = perf_stalls_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      fwd_a_q       <= FWD_RF;
      fwd_b_q       <= FWD_RF;
      perf_stalls_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign perf_stalls = perf_stalls_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; expectations follow HAZARD_FORWARDING_EN when defined.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rs2_used = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic        br_taken = 1'b0;
  logic        stall, bubble_ex, flush_ifid;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] perf_stalls;

  always #5 clk = ~clk;

  hazard_ctrl #(.NREG(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .br_taken     (br_taken),
    .stall        (stall),
    .bubble_ex    (bubble_ex),
    .flush_ifid   (flush_ifid),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .perf_stalls  (perf_stalls)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] rd, rs1, rs2;
    logic       rs2u, rw, mr;
  } instr_t;

  typedef struct {
    string       tag;
    logic        st, bu, fl;
    logic [1:0]  fa, fb;
    logic [15:0] perf;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     n_checks = 0;
  int     n_errors = 0;
  instr_t nop = '0;
  slot_t  frc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic rs2u, input logic rw, input logic mr);
    instr_t i;
    i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.rs2u = rs2u; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic exp_t ex_o(input string tag, input logic st, input logic bu, input logic fl,
                                input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] perf);
    exp_t e;
    e.tag = tag; e.st = st; e.bu = bu; e.fl = fl;
    e.fa = fa; e.fb = fb; e.perf = perf;
    return e;
  endfunction

  // One clock: drive decode inputs after the edge, queue what the DUT must show this cycle.
  task automatic cyc(input instr_t i, input logic br, input logic r, input logic push, input exp_t e);
    @(posedge clk);
    #1;
    id_valid     = i.v;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_rs2_used  = i.rs2u;
    id_rd        = i.rd;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    br_taken     = br;
    rst          = r;
    if (push) sb_q.push_back(e);
  endtask

  task automatic do_reset();
    cyc(nop, 1'b0, 1'b1, 1'b0, ex_o("none", 0, 0, 0, 0, 0, 0));
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq({mon_e.tag, ".stall"},  32'(stall),       32'(mon_e.st));
      check_eq({mon_e.tag, ".bubble"}, 32'(bubble_ex),   32'(mon_e.bu));
      check_eq({mon_e.tag, ".flush"},  32'(flush_ifid),  32'(mon_e.fl));
      check_eq({mon_e.tag, ".fwd_a"},  32'(fwd_a),       32'(mon_e.fa));
      check_eq({mon_e.tag, ".fwd_b"},  32'(fwd_b),       32'(mon_e.fb));
      check_eq({mon_e.tag, ".perf"},   32'(perf_stalls), 32'(mon_e.perf));
      check_eq({mon_e.tag, ".excl"},   32'(stall & flush_ifid), 32'd0);
    end
  end

  initial begin
    // Reset state
    do_reset();
    cyc(nop, 0, 0, 1, ex_o("rst", 0, 0, 0, 2'b00, 2'b00, 16'd0));

    // r0 is never a hazard nor a forward source
    do_reset();
    cyc(mk(4'd0, 4'd1, 4'd0, 0, 1, 1), 0, 0, 1, ex_o("r0.ld",  0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd4, 4'd0, 4'd0, 1, 1, 0), 0, 0, 1, ex_o("r0.use", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(nop,                            0, 0, 1, ex_o("r0.ex",  0, 0, 0, 2'b00, 2'b00, 16'd0));

    // rs2 ignored when the immediate is selected
    do_reset();
    cyc(mk(4'd2, 4'd1, 4'd0, 0, 1, 0), 0, 0, 1, ex_o("imm.prod", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd6, 4'd1, 4'd2, 0, 1, 0), 0, 0, 1, ex_o("imm.use",  0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(nop,                            0, 0, 1, ex_o("imm.ex",   0, 0, 0, 2'b00, 2'b00, 16'd0));

    // Taken branch during a load-use stall
    do_reset();
    cyc(mk(4'd3, 4'd1, 4'd0, 0, 1, 1), 0, 0, 1, ex_o("br.ld",    0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd4, 4'd3, 4'd5, 1, 1, 0), 0, 0, 1, ex_o("br.stall", 1, 1, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd4, 4'd3, 4'd5, 1, 1, 0), 1, 0, 1, ex_o("br.flush", 0, 1, 1, 2'b00, 2'b00, 16'd1));
    cyc(nop,                            0, 0, 1, ex_o("br.after", 0, 0, 0, 2'b00, 2'b00, 16'd1));

    // Reset asserted while stalled abandons the stall
    do_reset();
    cyc(mk(4'd2, 4'd1, 4'd0, 0, 1, 1), 0, 0, 1, ex_o("rs.ld",    0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd7, 4'd2, 4'd2, 1, 1, 0), 0, 1, 1, ex_o("rs.stall", 1, 1, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd7, 4'd2, 4'd2, 1, 1, 0), 0, 0, 1, ex_o("rs.after", 0, 0, 0, 2'b00, 2'b00, 16'd0));

`ifdef HAZARD_FORWARDING_EN
    // Load-use: one stall, then MEM/WB forward
    do_reset();
    cyc(mk(4'd3, 4'd1, 4'd0, 0, 1, 1), 0, 0, 1, ex_o("lu.ld",    0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd4, 4'd3, 4'd5, 1, 1, 0), 0, 0, 1, ex_o("lu.stall", 1, 1, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd4, 4'd3, 4'd5, 1, 1, 0), 0, 0, 1, ex_o("lu.go",    0, 0, 0, 2'b00, 2'b00, 16'd1));
    cyc(nop,                            0, 0, 1, ex_o("lu.ex",    0, 0, 0, 2'b10, 2'b00, 16'd1));

    // ALU result forwarded from EX/MEM, then from MEM/WB, then double-match priority
    do_reset();
    cyc(mk(4'd2, 4'd1, 4'd0, 0, 1, 0), 0, 0, 1, ex_o("f1.add", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd6, 4'd1, 4'd2, 1, 1, 0), 0, 0, 1, ex_o("f1.sub", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd2, 4'd1, 4'd0, 0, 1, 0), 0, 0, 1, ex_o("f1.ex",  0, 0, 0, 2'b00, 2'b01, 16'd0));
    cyc(mk(4'd8, 4'd9, 4'd0, 0, 1, 0), 0, 0, 1, ex_o("f2.mid", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd6, 4'd1, 4'd2, 1, 1, 0), 0, 0, 1, ex_o("f2.sub", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd2, 4'd1, 4'd0, 0, 1, 0), 0, 0, 1, ex_o("f2.ex",  0, 0, 0, 2'b00, 2'b10, 16'd0));
    cyc(mk(4'd2, 4'd1, 4'd0, 0, 1, 0), 0, 0, 1, ex_o("pr.p2",  0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd6, 4'd2, 4'd1, 1, 1, 0), 0, 0, 1, ex_o("pr.use", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(nop,                            0, 0, 1, ex_o("pr.ex",  0, 0, 0, 2'b01, 2'b00, 16'd0));
`else
    // Without forwarding a RAW dependency waits for the producer to leave WB
    do_reset();
    cyc(mk(4'd2, 4'd1, 4'd0, 0, 1, 0), 0, 0, 1, ex_o("nf.add", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd7, 4'd2, 4'd2, 1, 1, 0), 0, 0, 1, ex_o("nf.s1",  1, 1, 0, 2'b00, 2'b00, 16'd0));
    cyc(mk(4'd7, 4'd2, 4'd2, 1, 1, 0), 0, 0, 1, ex_o("nf.s2",  1, 1, 0, 2'b00, 2'b00, 16'd1));
    cyc(mk(4'd7, 4'd2, 4'd2, 1, 1, 0), 0, 0, 1, ex_o("nf.s3",  1, 1, 0, 2'b00, 2'b00, 16'd2));
    cyc(mk(4'd7, 4'd2, 4'd2, 1, 1, 0), 0, 0, 1, ex_o("nf.go",  0, 0, 0, 2'b00, 2'b00, 16'd3));
    cyc(nop,                            0, 0, 1, ex_o("nf.ex",  0, 0, 0, 2'b00, 2'b00, 16'd3));
`endif

    // Pin a load of r3 in EX so the dependent decode stalls every cycle
    do_reset();
    frc.valid = 1'b1; frc.rd = 4'd3; frc.reg_write = 1'b1; frc.mem_read = 1'b1;
    force dut.ex_q = frc;
    for (int k = 0; k < 70000; k++) begin
      cyc(mk(4'd4, 4'd3, 4'd5, 1, 1, 0), 0, 0,
          (k == 0 || k == 65534 || k == 65535 || k == 69999),
          ex_o($sformatf("sat.%0d", k), 1, 1, 0, 2'b00, 2'b00,
               (k > 65535) ? 16'hFFFF : 16'(k)));
    end
    release dut.ex_q;

    do_reset();
    cyc(nop, 0, 0, 1, ex_o("end.rst", 0, 0, 0, 2'b00, 2'b00, 16'd0));
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
